mod_exp_serial: RTL and testbench
=================================

MOD_EXP_SERIAL -- requirements
Module: mod_exp_serial

Interface
REQ-001 SHALL provide parameter WIDTH, default 64, giving the operand, modulus and result width in bits (minimum 4).
REQ-002 SHALL provide parameter EXP_WIDTH, default 64, giving the exponent width in bits (minimum 1).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port base  input  WIDTH  operand a; any value, including a >= n.
REQ-007 SHALL have port modulo  input  WIDTH  modulus n.
REQ-008 SHALL have port exponent  input  EXP_WIDTH  exponent b.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  high while result is valid; held until the next accepted start.
REQ-011 SHALL have port error  output  1  high with done when modulo was zero.
REQ-012 SHALL have port result  output  WIDTH  a^b mod n.

Function
REQ-013 SHALL compute a^b mod n by right-to-left binary exponentiation, using one bit-serial interleaved modular multiplier and no WIDTH x WIDTH combinational multiply.
REQ-014 Multiplier SHALL process one multiplier bit per cycle, MSB first: acc = 2*acc + (bit ? y : 0), then at most two conditional subtractions of n; WIDTH cycles per product; internal accumulator WIDTH+2 bits.
REQ-015 SHALL use states IDLE, LOAD, REDUCE, MUL, SQR, DONE.
REQ-016 IDLE/DONE: start=1 SHALL latch base, modulo and exponent, clear done and error, set busy, and go to LOAD; start=0 SHALL hold the state.
REQ-017 LOAD (1 cycle): modulo==0 SHALL go to DONE with error=1 and result=0; otherwise SHALL set the result register to 1 and go to REDUCE.
REQ-018 REDUCE SHALL replace base with (base*1) mod n on the multiplier, so that base < n for all later steps.
REQ-019 After REDUCE and after each step, with exponent register e:
- e==0: go to DONE with result = (result_reg mod n).
- e[0]==1 and MUL not yet done for this bit: go to MUL (result = result*base mod n).
- otherwise, if (e>>1)!=0: go to SQR (base = base^2 mod n), then shift e right by 1.
- otherwise: shift e and go to DONE; no squaring after the last set bit.
REQ-020 Exponent zero SHALL yield result 1, or 0 when n==1; n==1 SHALL yield 0 for any exponent.
REQ-021 Latency from the start-sampling edge to done=1 SHALL be L = 2 + WIDTH*(1 + popcount(b) + msb(b)), where msb(b) is the index of the highest set bit and msb(0)=0; the error path SHALL have L=2.
REQ-022 busy SHALL be 1 from the cycle after acceptance until the cycle done rises; busy and done SHALL never be high together.
REQ-023 start while busy SHALL be ignored, and the in-flight inputs SHALL be unaffected; input changes after acceptance SHALL have no effect.
REQ-024 result SHALL be 0 except in DONE, where it SHALL stay stable until the next accepted start.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE with busy=0, done=0, error=0 and result=0, and clear all internal registers, including mid-operation.
REQ-026 After rst_n is deasserted, the first start sampled high SHALL begin a fresh operation with no residue from the aborted one.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- WIDTH=16, EXP_WIDTH=16: a=4, n=497, b=13 -> result=445, error=0, done exactly 114 cycles after start.
- a=10, n=7, b=2 -> result=2 (a >= n path); a=3, n=7, b=0 -> result=1, L=18.
- a=5, n=1, b=3 -> result=0; a=9, n=0, b=5 -> error=1, result=0, L=2.
- start pulsed every cycle during 4^13 mod 497 -> single operation, result 445, done held until the next accepted start.
- rst_n low at cycle 40 of an operation -> all outputs 0 asynchronously; new start 3^5 mod 11 -> result=1.
- Random a, n, b at WIDTH=32 checked against a reference model; busy/done exclusivity and latency formula asserted on every run.

Source files
------------

// File: rtl/mod_exp_serial_if.sv
// Request/result bundle for the serial modular exponentiator.
// The master drives the operands and the start pulse; the slave returns the status flags and the result.
interface mod_exp_serial_if #(
    parameter int WIDTH     = 64,
    parameter int EXP_WIDTH = 64
);
    logic                 start;
    logic [WIDTH-1:0]     base;
    logic [WIDTH-1:0]     modulo;
    logic [EXP_WIDTH-1:0] exponent;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [WIDTH-1:0]     result;

    modport master (output start, base, modulo, exponent,
                    input  busy, done, error, result);
    modport slave  (input  start, base, modulo, exponent,
                    output busy, done, error, result);
endinterface

// File: rtl/mod_exp_serial.sv
// Right-to-left square-and-multiply a^b mod n on one bit-serial interleaved multiplier; done after 2+WIDTH*(1+popcount(b)+msb(b)) edges.
// start is sampled only in IDLE/DONE and is ignored while busy; done/result hold until the next accepted start.
module mod_exp_serial #(
    parameter int WIDTH     = 64,
    parameter int EXP_WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    mod_exp_serial_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, LOAD, REDUCE, MUL, SQR, DONE} state_t;

    state_t               state, state_nxt, dec;
    logic [WIDTH-1:0]     base_r, base_nxt, mod_r, mod_nxt, res_r, res_nxt;
    logic [WIDTH-1:0]     out_r, out_nxt, res_new;
    logic [EXP_WIDTH-1:0] exp_r, exp_nxt, e_eval;
    logic [WIDTH+1:0]     acc, acc_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic                 err_r, err_nxt, flag_eval, dec_shift;

    // Interleaved multiplier datapath: x is scanned MSB first, y is added and the sum reduced twice.
    logic [WIDTH-1:0] x_op, y_op, prod;
    logic [WIDTH+1:0] addend, sum, red1, red2, n_ext;
    logic             mul_last;

    assign x_op     = (state == MUL) ? res_r : base_r;
    assign y_op     = (state == REDUCE) ? WIDTH'(1) : base_r;
    assign n_ext    = {2'b00, mod_r};
    assign addend   = x_op[cnt] ? {2'b00, y_op} : '0;
    assign sum      = (acc << 1) + addend;
    assign red1     = (sum >= n_ext) ? sum - n_ext : sum;
    assign red2     = (red1 >= n_ext) ? red1 - n_ext : red1;
    assign prod     = red2[WIDTH-1:0];
    assign mul_last = (cnt == '0);

    assign bus.busy   = (state == LOAD) || (state == REDUCE) || (state == MUL) || (state == SQR);
    assign bus.done   = (state == DONE);
    assign bus.error  = err_r;
    assign bus.result = out_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            base_r <= '0;
            mod_r  <= '0;
            exp_r  <= '0;
            res_r  <= '0;
            out_r  <= '0;
            acc    <= '0;
            cnt    <= '0;
            err_r  <= 1'b0;
        end else begin
            state  <= state_nxt;
            base_r <= base_nxt;
            mod_r  <= mod_nxt;
            exp_r  <= exp_nxt;
            res_r  <= res_nxt;
            out_r  <= out_nxt;
            acc    <= acc_nxt;
            cnt    <= cnt_nxt;
            err_r  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        base_nxt  = base_r;
        mod_nxt   = mod_r;
        exp_nxt   = exp_r;
        res_nxt   = res_r;
        out_nxt   = out_r;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        err_nxt   = err_r;
        res_new   = res_r;

        // Step decision: a MUL state means the multiply for the current bit is already done;
        // leaving SQR evaluates the exponent as it will be after the shift.
        e_eval    = (state == SQR) ? (exp_r >> 1) : exp_r;
        flag_eval = (state == MUL);
        dec       = DONE;
        dec_shift = 1'b0;
        if (e_eval == '0) begin
            dec = DONE;
        end else if (e_eval[0] && !flag_eval) begin
            dec = MUL;
        end else if ((e_eval >> 1) != '0) begin
            dec = SQR;
        end else begin
            dec       = DONE;
            dec_shift = 1'b1;
        end

        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    base_nxt  = bus.base;
                    mod_nxt   = bus.modulo;
                    exp_nxt   = bus.exponent;
                    res_nxt   = '0;
                    out_nxt   = '0;
                    err_nxt   = 1'b0;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (mod_r == '0) begin
                    err_nxt   = 1'b1;
                    out_nxt   = '0;
                    state_nxt = DONE;
                end else begin
                    res_nxt   = WIDTH'(1);
                    acc_nxt   = '0;
                    cnt_nxt   = CNT_W'(WIDTH - 1);
                    state_nxt = REDUCE;
                end
            end
            REDUCE, MUL, SQR: begin
                acc_nxt = red2;
                cnt_nxt = cnt - 1'b1;
                if (mul_last) begin
                    if (state == MUL) begin
                        res_nxt = prod;
                        res_new = prod;
                    end else begin
                        base_nxt = prod;
                    end
                    exp_nxt   = dec_shift ? (e_eval >> 1) : e_eval;
                    acc_nxt   = '0;
                    cnt_nxt   = CNT_W'(WIDTH - 1);
                    state_nxt = dec;
                    // The result register still holds its initial 1 when n==1 and no multiply ran.
                    if (dec == DONE) begin
                        out_nxt = (mod_r == WIDTH'(1)) ? '0 : res_new;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mod_exp_serial.sv
// Bench for mod_exp_serial: directed cases at WIDTH=16 and randomized cases at WIDTH=32 against a reference model.
module tb_mod_exp_serial;
    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   proto_err = 0;

    mod_exp_serial_if #(.WIDTH(16), .EXP_WIDTH(16)) if16 ();
    mod_exp_serial_if #(.WIDTH(32), .EXP_WIDTH(32)) if32 ();

    mod_exp_serial #(.WIDTH(16), .EXP_WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
    mod_exp_serial #(.WIDTH(32), .EXP_WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: plain square-and-multiply with 64-bit intermediate products.
    function automatic logic [31:0] ref_pow(input logic [31:0] a, input logic [31:0] n, input logic [31:0] b);
        logic [63:0] r, x, nn;
        logic [31:0] e;
        if (n == 0) return 32'd0;
        nn = {32'd0, n};
        r  = 64'd1 % nn;
        x  = {32'd0, a} % nn;
        e  = b;
        while (e != 0) begin
            if (e[0]) r = (r * x) % nn;
            x = (x * x) % nn;
            e = e >> 1;
        end
        return r[31:0];
    endfunction

    function automatic int ref_lat(input int w, input logic [31:0] n, input logic [31:0] b);
        int m;
        m = 0;
        if (n == 0) return 2;
        for (int i = 0; i < 32; i++) if (b[i]) m = i;
        return 2 + w * (1 + $countones(b) + m);
    endfunction

    // Runs one operation; lat counts edges from the accepting edge to the edge after which done is seen.
    task automatic op16(input logic [15:0] a, input logic [15:0] n, input logic [15:0] b,
                        output logic [15:0] r, output logic e, output int lat);
        @(negedge clk);
        if16.base = a; if16.modulo = n; if16.exponent = b; if16.start = 1'b1;
        @(posedge clk); lat = 1;
        @(negedge clk); if16.start = 1'b0;
        while (!if16.done && lat < 5000) begin
            if (!if16.busy || if16.result !== 16'd0) proto_err++;
            @(posedge clk); lat++;
            @(negedge clk);
        end
        if (if16.busy && if16.done) proto_err++;
        r = if16.result; e = if16.error;
    endtask

    task automatic op32(input logic [31:0] a, input logic [31:0] n, input logic [31:0] b,
                        output logic [31:0] r, output logic e, output int lat);
        @(negedge clk);
        if32.base = a; if32.modulo = n; if32.exponent = b; if32.start = 1'b1;
        @(posedge clk); lat = 1;
        @(negedge clk); if32.start = 1'b0;
        while (!if32.done && lat < 5000) begin
            if (!if32.busy || if32.result !== 32'd0) proto_err++;
            @(posedge clk); lat++;
            @(negedge clk);
        end
        if (if32.busy && if32.done) proto_err++;
        r = if32.result; e = if32.error;
    endtask

    task automatic test_reset();
        logic [3:0] s16, s32;
        rst_n = 1'b0;
        if16.start = 0; if16.base = 0; if16.modulo = 0; if16.exponent = 0;
        if32.start = 0; if32.base = 0; if32.modulo = 0; if32.exponent = 0;
        repeat (3) @(negedge clk);
        s16 = {if16.busy, if16.done, if16.error, |if16.result};
        s32 = {if32.busy, if32.done, if32.error, |if32.result};
        checks++;
        if (s16 !== 4'b0000) begin failures++; $display("FAIL reset16 busy/done/error/result got=%b want=0000", s16); end
        checks++;
        if (s32 !== 4'b0000) begin failures++; $display("FAIL reset32 busy/done/error/result got=%b want=0000", s32); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [15:0] r; logic e; int lat;
        op16(16'd4, 16'd497, 16'd13, r, e, lat);
        checks++; if (r !== 16'd445) begin failures++; $display("FAIL basic_result got=%0d want=445", r); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL basic_error got=%b want=0", e); end
        checks++; if (lat !== 114) begin failures++; $display("FAIL basic_latency got=%0d want=114", lat); end
        repeat (4) @(negedge clk);
        checks++;
        if (if16.done !== 1'b1 || if16.result !== 16'd445)
            begin failures++; $display("FAIL basic_hold done=%b result=%0d want done=1 result=445", if16.done, if16.result); end
    endtask

    task automatic test_reduce_and_zero_exp();
        logic [15:0] r; logic e; int lat;
        op16(16'd10, 16'd7, 16'd2, r, e, lat);
        checks++; if (r !== 16'd2) begin failures++; $display("FAIL a_ge_n_result got=%0d want=2", r); end
        checks++; if (lat !== 50) begin failures++; $display("FAIL a_ge_n_latency got=%0d want=50", lat); end
        op16(16'd3, 16'd7, 16'd0, r, e, lat);
        checks++; if (r !== 16'd1) begin failures++; $display("FAIL exp0_result got=%0d want=1", r); end
        checks++; if (lat !== 18) begin failures++; $display("FAIL exp0_latency got=%0d want=18", lat); end
    endtask

    task automatic test_mod_one_and_error();
        logic [15:0] r; logic e; int lat;
        op16(16'd5, 16'd1, 16'd3, r, e, lat);
        checks++; if (r !== 16'd0) begin failures++; $display("FAIL mod1_result got=%0d want=0", r); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL mod1_error got=%b want=0", e); end
        op16(16'd9, 16'd0, 16'd5, r, e, lat);
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL mod0_error got=%b want=1", e); end
        checks++; if (r !== 16'd0) begin failures++; $display("FAIL mod0_result got=%0d want=0", r); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL mod0_latency got=%0d want=2", lat); end
    endtask

    task automatic test_back_to_back();
        int lat, dones;
        @(negedge clk);
        if16.base = 16'd4; if16.modulo = 16'd497; if16.exponent = 16'd13; if16.start = 1'b1;
        lat = 0; dones = 0;
        while (dones == 0 && lat < 3000) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (if16.done) dones++;
            else begin
                if16.base = 16'($urandom); if16.modulo = 16'($urandom); if16.exponent = 16'($urandom);
            end
        end
        if16.start = 1'b0;
        checks++; if (lat !== 114) begin failures++; $display("FAIL b2b_latency got=%0d want=114", lat); end
        checks++; if (if16.result !== 16'd445) begin failures++; $display("FAIL b2b_result got=%0d want=445", if16.result); end
        repeat (5) @(negedge clk);
        checks++;
        if (if16.done !== 1'b1 || if16.result !== 16'd445)
            begin failures++; $display("FAIL b2b_hold done=%b result=%0d want done=1 result=445", if16.done, if16.result); end
        if16.base = 16'd2; if16.modulo = 16'd5; if16.exponent = 16'd3; if16.start = 1'b1;
        @(negedge clk); if16.start = 1'b0;
        checks++;
        if (if16.done !== 1'b0 || if16.result !== 16'd0 || if16.busy !== 1'b1)
            begin failures++; $display("FAIL b2b_restart done=%b busy=%b result=%0d want done=0 busy=1 result=0",
                                       if16.done, if16.busy, if16.result); end
        lat = 0;
        while (!if16.done && lat < 3000) begin @(negedge clk); lat++; end
        checks++; if (if16.result !== 16'd3) begin failures++; $display("FAIL b2b_second_result got=%0d want=3", if16.result); end
    endtask

    task automatic test_reset_midop();
        logic [15:0] r; logic e; int lat;
        logic [3:0] s;
        @(negedge clk);
        if16.base = 16'd4; if16.modulo = 16'd497; if16.exponent = 16'd13; if16.start = 1'b1;
        @(negedge clk); if16.start = 1'b0;
        repeat (39) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 s = {if16.busy, if16.done, if16.error, |if16.result};
        checks++; if (s !== 4'b0000) begin failures++; $display("FAIL async_reset busy/done/error/result got=%b want=0000", s); end
        @(negedge clk); rst_n = 1'b1;
        op16(16'd3, 16'd11, 16'd5, r, e, lat);
        checks++; if (r !== 16'd1) begin failures++; $display("FAIL post_reset_result got=%0d want=1", r); end
        checks++; if (lat !== 82) begin failures++; $display("FAIL post_reset_latency got=%0d want=82", lat); end
    endtask

    task automatic test_random32();
        logic [31:0] a, n, b, r, exp_r; logic e; int lat, exp_lat;
        for (int i = 0; i < 25; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       n = 32'd0;
                1:       n = 32'd1;
                2:       n = $urandom_range(2, 20);
                default: n = $urandom;
            endcase
            b = $urandom >> $urandom_range(4, 31);
            op32(a, n, b, r, e, lat);
            exp_r   = ref_pow(a, n, b);
            exp_lat = ref_lat(32, n, b);
            checks++;
            if (r !== exp_r || e !== (n == 0) || lat !== exp_lat) begin
                failures++;
                $display("FAIL rand32 a=%0d n=%0d b=%0d got r=%0d err=%b lat=%0d want r=%0d err=%b lat=%0d",
                         a, n, b, r, e, lat, exp_r, (n == 0), exp_lat);
            end
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (proto_err !== 0) begin failures++; $display("FAIL busy_done_protocol violations got=%0d want=0", proto_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reduce_and_zero_exp();
        test_mod_one_and_error();
        test_back_to_back();
        test_reset_midop();
        test_random32();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
